control: RTL

- Multicycle FSM sequencer for the RV32I datapath.
- Decodes opcode/funct3/funct7/br_en from the IR and drives every datapath load enable and mux select, plus the memory read/write handshake and byte enables.
- One instruction at a time: fetch, decode, execute, then return to fetch.

---
 rtl/control_if.sv | 25 ++
 rtl/control.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_if.sv
// rtl/control_if.sv - memory request/response handshake between control and memory
// Carries the read/write strobes, byte enables, completion pulse and low address bits.
interface control_if;
   logic [1:0] mem_addr_lo;
   logic       mem_resp;
   logic       mem_read;
   logic       mem_write;
   logic [3:0] mem_byte_enable;

   modport master (
      input  mem_addr_lo,
      input  mem_resp,
      output mem_read,
      output mem_write,
      output mem_byte_enable
   );

   modport slave (
      output mem_addr_lo,
      output mem_resp,
      input  mem_read,
      input  mem_write,
      input  mem_byte_enable
   );
endinterface

// File: rtl/control.sv
// rtl/control.sv - multicycle RV32I sequencer: fetch, decode, execute, back to fetch
// Outputs are decoded combinationally from the current state and IR fields; rst forces them all low.
module control (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       br_en,
   control_if.master  mem,
   output logic       load_pc,
   output logic       load_ir,
   output logic       load_regfile,
   output logic       load_mar,
   output logic       load_mdr,
   output logic       load_data_out,
   output logic [1:0] pcmux_sel,
   output logic       alumux1_sel,
   output logic [2:0] alumux2_sel,
   output logic [3:0] regfilemux_sel,
   output logic       marmux_sel,
   output logic       cmpmux_sel,
   output logic [2:0] cmpop,
   output logic [2:0] aluop
);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SRA = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd3;
   localparam logic [2:0] ALU_SRL = 3'd5;

   localparam logic [2:0] CMP_BLT  = 3'b100;
   localparam logic [2:0] CMP_BLTU = 3'b110;

   typedef enum logic [4:0] {
      S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
      S_LUI, S_AUIPC, S_JAL, S_JALR, S_BR, S_IMM, S_REG, S_SKIP,
      S_CALC_LD, S_LD1, S_LD2,
      S_CALC_ST, S_ST1, S_ST2
   } state_e;

   state_e state_q, state_d;

   // Only the sub/sra select bit of funct7 matters in RV32I.
   logic unused_funct7;
   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH1;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d             = state_q;
      load_pc             = 1'b0;
      load_ir             = 1'b0;
      load_regfile        = 1'b0;
      load_mar            = 1'b0;
      load_mdr            = 1'b0;
      load_data_out       = 1'b0;
      pcmux_sel           = 2'd0;
      alumux1_sel         = 1'b0;
      alumux2_sel         = 3'd0;
      regfilemux_sel      = 4'd0;
      marmux_sel          = 1'b0;
      cmpmux_sel          = 1'b0;
      cmpop               = 3'd0;
      aluop               = ALU_ADD;
      mem.mem_read        = 1'b0;
      mem.mem_write       = 1'b0;
      mem.mem_byte_enable = 4'b0000;

      if (!rst) begin
         unique case (state_q)
            S_FETCH1: begin
               load_mar = 1'b1;
               state_d  = S_FETCH2;
            end
            S_FETCH2: begin
               mem.mem_read = 1'b1;
               load_mdr     = 1'b1;
               if (mem.mem_resp) state_d = S_FETCH3;
            end
            S_FETCH3: begin
               load_ir = 1'b1;
               state_d = S_DECODE;
            end
            S_DECODE: begin
               case (opcode)
                  OP_LUI:   state_d = S_LUI;
                  OP_AUIPC: state_d = S_AUIPC;
                  OP_JAL:   state_d = S_JAL;
                  OP_JALR:  state_d = S_JALR;
                  OP_BR:    state_d = S_BR;
                  OP_LOAD:  state_d = S_CALC_LD;
                  OP_STORE: state_d = S_CALC_ST;
                  OP_IMM:   state_d = S_IMM;
                  OP_REG:   state_d = S_REG;
                  default:  state_d = S_SKIP;
               endcase
            end
            S_LUI: begin
               regfilemux_sel = 4'd2;
               load_regfile   = 1'b1;
               load_pc        = 1'b1;
               state_d        = S_FETCH1;
            end
            S_AUIPC: begin
               alumux1_sel  = 1'b1;
               alumux2_sel  = 3'd1;
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               state_d      = S_FETCH1;
            end
            S_IMM, S_REG: begin
               alumux2_sel  = (state_q == S_REG) ? 3'd5 : 3'd0;
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               state_d      = S_FETCH1;
               // slt/sltu go through the comparator, not the ALU.
               case (funct3)
                  3'b010: begin
                     cmpmux_sel     = (state_q == S_IMM);
                     cmpop          = CMP_BLT;
                     regfilemux_sel = 4'd1;
                  end
                  3'b011: begin
                     cmpmux_sel     = (state_q == S_IMM);
                     cmpop          = CMP_BLTU;
                     regfilemux_sel = 4'd1;
                  end
                  3'b101:  aluop = funct7[5] ? ALU_SRA : ALU_SRL;
                  3'b000:  aluop = (state_q == S_REG && funct7[5]) ? ALU_SUB : ALU_ADD;
                  default: aluop = funct3;
               endcase
            end
            S_BR: begin
               alumux1_sel = 1'b1;
               alumux2_sel = 3'd2;
               cmpop       = funct3;
               pcmux_sel   = br_en ? 2'd1 : 2'd0;
               load_pc     = 1'b1;
               state_d     = S_FETCH1;
            end
            S_JAL: begin
               alumux1_sel    = 1'b1;
               alumux2_sel    = 3'd4;
               pcmux_sel      = 2'd1;
               regfilemux_sel = 4'd4;
               load_regfile   = 1'b1;
               load_pc        = 1'b1;
               state_d        = S_FETCH1;
            end
            S_JALR: begin
               pcmux_sel      = 2'd2;
               regfilemux_sel = 4'd4;
               load_regfile   = 1'b1;
               load_pc        = 1'b1;
               state_d        = S_FETCH1;
            end
            S_SKIP: begin
               load_pc = 1'b1;
               state_d = S_FETCH1;
            end
            S_CALC_LD: begin
               marmux_sel = 1'b1;
               load_mar   = 1'b1;
               state_d    = S_LD1;
            end
            S_LD1: begin
               mem.mem_read = 1'b1;
               load_mdr     = 1'b1;
               if (mem.mem_resp) state_d = S_LD2;
            end
            S_LD2: begin
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               state_d      = S_FETCH1;
               case (funct3)
                  3'b000:  regfilemux_sel = 4'd5;
                  3'b001:  regfilemux_sel = 4'd7;
                  3'b010:  regfilemux_sel = 4'd3;
                  3'b100:  regfilemux_sel = 4'd6;
                  3'b101:  regfilemux_sel = 4'd8;
                  default: regfilemux_sel = 4'd0;
               endcase
            end
            S_CALC_ST: begin
               alumux2_sel   = 3'd3;
               marmux_sel    = 1'b1;
               load_mar      = 1'b1;
               load_data_out = 1'b1;
               state_d       = S_ST1;
            end
            S_ST1: begin
               mem.mem_write = 1'b1;
               case (funct3)
                  3'b000:  mem.mem_byte_enable = 4'b0001 << mem.mem_addr_lo;
                  3'b001:  mem.mem_byte_enable = 4'b0011 << mem.mem_addr_lo;
                  3'b010:  mem.mem_byte_enable = 4'b1111;
                  default: mem.mem_byte_enable = 4'b0000;
               endcase
               if (mem.mem_resp) state_d = S_ST2;
            end
            S_ST2: begin
               load_pc = 1'b1;
               state_d = S_FETCH1;
            end
            default: state_d = S_FETCH1;
         endcase
      end
   end

endmodule
